// File: rtl/ps2_kbd_pkg.sv
// Shared constants, types and lookup tables for the PS/2 Set-2 keyboard event decoder.
// Key indices reuse the Set-2 make code for plain keys; extended keys, F7 and Pause are
// folded into code points that no plain key uses, so one 7-bit index space covers everything.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam logic [6:0] LCTRL_IDX = 7'h14;
  localparam logic [6:0] LSHFT_IDX = 7'h12;
  localparam logic [6:0] LALT_IDX  = 7'h11;
  localparam logic [6:0] LWIN_IDX  = 7'h1F;
  localparam logic [6:0] RCTRL_IDX = 7'h18;
  localparam logic [6:0] RSHFT_IDX = 7'h59;
  localparam logic [6:0] RALT_IDX  = 7'h13;
  localparam logic [6:0] RWIN_IDX  = 7'h27;
  localparam logic [6:0] CAPS_IDX  = 7'h58;
  localparam logic [6:0] PAUSE_IDX = 7'h7F;
  localparam logic [6:0] F7_IDX    = 7'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK,
    ST_PAUSE
  } kbd_state_e;

  typedef struct packed {
    logic [7:0] ascii;
    logic [7:0] mods;
    logic       is_break;
    logic [6:0] key_idx;
  } evt_t;

  typedef struct packed {
    logic       hit;
    logic [6:0] idx;
  } key_map_t;

  // Bytes the keyboard sends as command responses rather than scancodes.
  function automatic logic is_ctrl_resp(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  // {extended, code} -> key index; hit=0 for codes with no key behind them.
  function automatic key_map_t keymap(input logic ext, input logic [7:0] code);
    key_map_t km;
    km.hit = 1'b0;
    km.idx = 7'h00;
    if (!ext) begin
      case (code)
        8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E,
        8'h11, 8'h12, 8'h14, 8'h15, 8'h16, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E,
        8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'h2E,
        8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h3E,
        8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E,
        8'h52, 8'h54, 8'h55, 8'h58, 8'h59, 8'h5A, 8'h5B, 8'h5D, 8'h66, 8'h69, 8'h6B, 8'h6C,
        8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79, 8'h7A, 8'h7B,
        8'h7C, 8'h7D, 8'h7E: begin
          km.hit = 1'b1;
          km.idx = code[6:0];
        end
        8'h83: begin
          km.hit = 1'b1;
          km.idx = F7_IDX;
        end
        default: km.hit = 1'b0;
      endcase
    end else begin
      km.hit = 1'b1;
      case (code)
        8'h11:   km.idx = RALT_IDX;
        8'h14:   km.idx = RCTRL_IDX;
        8'h1F:   km.idx = LWIN_IDX;
        8'h27:   km.idx = RWIN_IDX;
        8'h2F:   km.idx = 7'h2F;  // menu
        8'h4A:   km.idx = 7'h38;  // keypad /
        8'h5A:   km.idx = 7'h39;  // keypad enter
        8'h69:   km.idx = 7'h60;  // end
        8'h6B:   km.idx = 7'h61;  // left
        8'h6C:   km.idx = 7'h62;  // home
        8'h70:   km.idx = 7'h63;  // insert
        8'h71:   km.idx = 7'h64;  // delete
        8'h72:   km.idx = 7'h65;  // down
        8'h74:   km.idx = 7'h67;  // right
        8'h75:   km.idx = 7'h68;  // up
        8'h7A:   km.idx = 7'h6A;  // page down
        8'h7D:   km.idx = 7'h6D;  // page up
        8'h7C:   km.idx = 7'h6E;  // print screen (the E0 12 fake-shift prefix stays unmapped)
        default: km.hit = 1'b0;
      endcase
    end
    return km;
  endfunction

  // Printable character for a key index; letters honour shift^caps, everything else shift only.
  function automatic logic [7:0] ascii_lookup(input logic [6:0] idx, input logic shift,
                                              input logic caps);
    logic [7:0] lo;
    logic [7:0] hi;
    logic       letter;
    lo     = 8'hFF;
    hi     = 8'hFF;
    letter = 1'b0;
    case (idx)
      7'h1C: begin lo = "a"; letter = 1'b1; end
      7'h32: begin lo = "b"; letter = 1'b1; end
      7'h21: begin lo = "c"; letter = 1'b1; end
      7'h23: begin lo = "d"; letter = 1'b1; end
      7'h24: begin lo = "e"; letter = 1'b1; end
      7'h2B: begin lo = "f"; letter = 1'b1; end
      7'h34: begin lo = "g"; letter = 1'b1; end
      7'h33: begin lo = "h"; letter = 1'b1; end
      7'h43: begin lo = "i"; letter = 1'b1; end
      7'h3B: begin lo = "j"; letter = 1'b1; end
      7'h42: begin lo = "k"; letter = 1'b1; end
      7'h4B: begin lo = "l"; letter = 1'b1; end
      7'h3A: begin lo = "m"; letter = 1'b1; end
      7'h31: begin lo = "n"; letter = 1'b1; end
      7'h44: begin lo = "o"; letter = 1'b1; end
      7'h4D: begin lo = "p"; letter = 1'b1; end
      7'h15: begin lo = "q"; letter = 1'b1; end
      7'h2D: begin lo = "r"; letter = 1'b1; end
      7'h1B: begin lo = "s"; letter = 1'b1; end
      7'h2C: begin lo = "t"; letter = 1'b1; end
      7'h3C: begin lo = "u"; letter = 1'b1; end
      7'h2A: begin lo = "v"; letter = 1'b1; end
      7'h1D: begin lo = "w"; letter = 1'b1; end
      7'h22: begin lo = "x"; letter = 1'b1; end
      7'h35: begin lo = "y"; letter = 1'b1; end
      7'h1A: begin lo = "z"; letter = 1'b1; end
      7'h16: begin lo = 8'h31; hi = 8'h21; end
      7'h1E: begin lo = 8'h32; hi = 8'h40; end
      7'h26: begin lo = 8'h33; hi = 8'h23; end
      7'h25: begin lo = 8'h34; hi = 8'h24; end
      7'h2E: begin lo = 8'h35; hi = 8'h25; end
      7'h36: begin lo = 8'h36; hi = 8'h5E; end
      7'h3D: begin lo = 8'h37; hi = 8'h26; end
      7'h3E: begin lo = 8'h38; hi = 8'h2A; end
      7'h46: begin lo = 8'h39; hi = 8'h28; end
      7'h45: begin lo = 8'h30; hi = 8'h29; end
      7'h0E: begin lo = 8'h60; hi = 8'h7E; end
      7'h4E: begin lo = 8'h2D; hi = 8'h5F; end
      7'h55: begin lo = 8'h3D; hi = 8'h2B; end
      7'h54: begin lo = 8'h5B; hi = 8'h7B; end
      7'h5B: begin lo = 8'h5D; hi = 8'h7D; end
      7'h5D: begin lo = 8'h5C; hi = 8'h7C; end
      7'h4C: begin lo = 8'h3B; hi = 8'h3A; end
      7'h52: begin lo = 8'h27; hi = 8'h22; end
      7'h41: begin lo = 8'h2C; hi = 8'h3C; end
      7'h49: begin lo = 8'h2E; hi = 8'h3E; end
      7'h4A: begin lo = 8'h2F; hi = 8'h3F; end
      7'h5A: begin lo = 8'h0D; hi = 8'h0D; end
      7'h66: begin lo = 8'h08; hi = 8'h08; end
      7'h0D: begin lo = 8'h09; hi = 8'h09; end
      7'h29: begin lo = 8'h20; hi = 8'h20; end
      default: begin lo = 8'hFF; hi = 8'hFF; end
    endcase
    if (letter) return (shift ^ caps) ? (lo & 8'hDF) : lo;
    return shift ? hi : lo;
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Purpose: first-word-fall-through FIFO with occupancy count, full and empty flags.
// Latency: a push is visible at the head the cycle after the writing edge.
// Backpressure: push is accepted when not full or when a pop happens in the same cycle.
module kbd_event_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     wr_clk,
  input  logic                     rst_n,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_fire;
  logic             pop_fire;

  assign empty     = (count == '0);
  assign full      = (count == CNT_FULL);
  assign pop_fire  = pop_rdy && !empty;
  assign push_fire = push_vld && (!full || pop_fire);
  // Gated so the head reads as zero whenever nothing is queued, including after reset.
  assign head_dat  = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge wr_clk) begin
    if (push_fire) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_fire)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_event_decoder.sv
// Purpose: turns PS/2 Set-2 scancode bytes into queued key events plus held-key bitmap and caps lock.
// Latency: event pushed on the edge sampling its final byte; head valid the following cycle.
// Backpressure: evt_ready pops the FWFT head; pushes into a full FIFO are dropped and set overflow.
// Build option TYPEMATIC_FILTER_EN: suppress events for makes of keys already held.
module ps2_kbd_event_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int NUM_KEYS  = 128,
  parameter int PAUSE_LEN = 7
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   evt_ready,
  output logic                   evt_valid,
  output logic [23:0]            evt_data,
  output logic [NUM_KEYS-1:0]    key_state,
  output logic                   caps_lock,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int PCW = $clog2(PAUSE_LEN + 1);
  localparam logic [PCW-1:0] PCNT_ONE  = PCW'(1);
  localparam logic [PCW-1:0] PCNT_LAST = PCW'(PAUSE_LEN - 1);

  kbd_state_e     state;
  kbd_state_e     state_nxt;
  logic [PCW-1:0] pcnt;
  logic [PCW-1:0] pcnt_nxt;
  logic           dec_vld;
  logic           dec_ext;
  logic           dec_brk;
  logic           pause_evt;
  key_map_t       km;
  logic           key_hit;
  logic           key_held;
  logic [7:0]     mods;
  evt_t           evt;
  logic           evt_push;
  logic           fifo_full;
  logic           fifo_empty;

  // Prefix tracking: which state we are in decides how the next plain byte is read.
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    dec_vld   = 1'b0;
    dec_ext   = 1'b0;
    dec_brk   = 1'b0;
    pause_evt = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == PS2_BRK)        state_nxt = ST_BRK;
          else if (rx_data == PS2_EXT)   state_nxt = ST_EXT;
          else if (rx_data == PS2_PAUSE) begin
            state_nxt = ST_PAUSE;
            pcnt_nxt  = '0;
          end
          else if (!is_ctrl_resp(rx_data)) dec_vld = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK)      state_nxt = ST_EXT_BRK;
          else if (rx_data == PS2_EXT) state_nxt = ST_EXT;
          else begin
            dec_vld   = 1'b1;
            dec_ext   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          // A fresh prefix mid-break means the earlier sequence was cut short; start over.
          if (rx_data == PS2_EXT)      state_nxt = ST_EXT;
          else if (rx_data == PS2_BRK) state_nxt = ST_BRK;
          else begin
            dec_vld   = 1'b1;
            dec_brk   = 1'b1;
            dec_ext   = (state == ST_EXT_BRK);
            state_nxt = ST_IDLE;
          end
        end
        ST_PAUSE: begin
          // Pause has no break code; swallow its tail blindly and report a single make.
          if (pcnt == PCNT_LAST) begin
            pause_evt = 1'b1;
            pcnt_nxt  = '0;
            state_nxt = ST_IDLE;
          end else begin
            pcnt_nxt = pcnt + PCNT_ONE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM and pause-counter registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      pcnt  <= '0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;
    end
  end

  assign km       = keymap(dec_ext, rx_data);
  assign key_hit  = dec_vld && km.hit;
  assign key_held = key_state[km.idx];

  // Event assembly: modifiers and caps are sampled before this key's own effect lands.
  always_comb begin
    mods = {key_state[LCTRL_IDX], key_state[LSHFT_IDX], key_state[LALT_IDX], key_state[LWIN_IDX],
            key_state[RCTRL_IDX], key_state[RSHFT_IDX], key_state[RALT_IDX], key_state[RWIN_IDX]};
    evt          = '0;
    evt.key_idx  = pause_evt ? PAUSE_IDX : km.idx;
    evt.is_break = dec_brk;
    evt.mods     = mods;
    if (dec_brk || mods[7] || mods[5] || mods[4] || mods[3] || mods[1] || mods[0])
      evt.ascii = 8'hFF;
    else
      evt.ascii = ascii_lookup(evt.key_idx, mods[6] || mods[2], caps_lock);
  end

`ifdef TYPEMATIC_FILTER_EN
  assign evt_push = pause_evt || (key_hit && !(!dec_brk && key_held));
`else
  assign evt_push = pause_evt || key_hit;
`endif

  // Held-key bitmap and caps-lock toggle follow every decoded key, even if its event is dropped.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      key_state <= '0;
      caps_lock <= 1'b0;
    end else if (key_hit) begin
      key_state[km.idx] <= !dec_brk;
      if (!dec_brk && (km.idx == CAPS_IDX)) caps_lock <= !caps_lock;
    end
  end

  // Sticky drop flag: a push against a full FIFO with no simultaneous pop.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)                                  overflow <= 1'b0;
    else if (evt_push && fifo_full && !evt_ready)  overflow <= 1'b1;
  end

  kbd_event_fifo #(
    .WIDTH (24),
    .DEPTH (DEPTH)
  ) u_fifo (
    .wr_clk   (CLOCK_50),
    .rst_n    (reset_n),
    .push_vld (evt_push),
    .push_dat (evt),
    .pop_rdy  (evt_ready),
    .head_dat (evt_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign evt_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_kbd_event_decoder.sv
// Directed bench for the PS/2 event decoder: hand-computed event words, bitmap and FIFO status.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Event word = {ascii, mods, is_break, key_idx}.
module tb_ps2_kbd_event_decoder;

  localparam int DEPTH = 16;

  logic         CLOCK_50 = 1'b0;
  logic         reset_n  = 1'b0;
  logic [7:0]   rx_data  = 8'h00;
  logic         rx_valid = 1'b0;
  logic         evt_ready = 1'b0;
  logic         evt_valid;
  logic [23:0]  evt_data;
  logic [127:0] key_state;
  logic         caps_lock;
  logic [4:0]   fifo_count;
  logic         overflow;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [23:0] MK_A  = 24'h61001C;
  localparam logic [23:0] BRK_A = 24'hFF009C;

  ps2_kbd_event_decoder #(.DEPTH(DEPTH), .NUM_KEYS(128), .PAUSE_LEN(7)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .key_state  (key_state),
    .caps_lock  (caps_lock),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One byte strobe; optionally pops in the same cycle. Starts and ends on a falling edge.
  task automatic send_rdy(input logic [7:0] b, input logic rdy);
    rx_data   = b;
    rx_valid  = 1'b1;
    evt_ready = rdy;
    @(negedge CLOCK_50);
    rx_valid  = 1'b0;
    evt_ready = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    send_rdy(b, 1'b0);
  endtask

  // Check the head entry, then pop it.
  task automatic pop(input string tag, input logic [23:0] exp);
    chk({tag, "_vld"}, evt_valid, 1'b1);
    chk(tag, evt_data, exp);
    evt_ready = 1'b1;
    @(negedge CLOCK_50);
    evt_ready = 1'b0;
  endtask

  // Reset asserted asynchronously mid-cycle.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic fill_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      send(8'h1C);
      send(8'hF0);
      send(8'h1C);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge CLOCK_50);
    chk("rst_vld",  evt_valid, 1'b0);
    chk("rst_dat",  evt_data, 24'h0);
    chk("rst_ks",   key_state, 128'h0);
    chk("rst_caps", caps_lock, 1'b0);
    chk("rst_cnt",  fifo_count, 5'd0);
    chk("rst_ovf",  overflow, 1'b0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);

    // 1: plain make and break of 'a'
    send(8'h1C);
    chk("t1_vld_lat", evt_valid, 1'b1);
    chk("t1_cnt1", fifo_count, 5'd1);
    chk("t1_held", key_state[7'h1C], 1'b1);
    send(8'hF0);
    chk("t1_prefix_noevt", fifo_count, 5'd1);
    send(8'h1C);
    chk("t1_cnt2", fifo_count, 5'd2);
    chk("t1_ks", key_state, 128'h0);
    pop("t1_make", MK_A);
    pop("t1_brk", BRK_A);
    chk("t1_empty", evt_valid, 1'b0);

    // 2: shift, caps lock, shift+caps, digits
    do_reset();
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    chk("t2_ks", key_state, 128'h0);
    pop("t2_lshft_mk", 24'hFF0012);
    pop("t2_A_shift",  24'h41401C);
    pop("t2_A_brk",    24'hFF409C);
    pop("t2_lshft_brk", 24'hFF4092);
    send(8'h58); send(8'hF0); send(8'h58);
    chk("t2_caps", caps_lock, 1'b1);
    pop("t2_caps_mk",  24'hFF0058);
    pop("t2_caps_brk", 24'hFF00D8);
    send(8'h1C);
    pop("t2_A_caps", 24'h41001C);
    send(8'hF0); send(8'h1C);
    pop("t2_A_caps_brk", BRK_A);
    send(8'h12); send(8'h1C); send(8'h16);
    pop("t2_lshft_mk2", 24'hFF0012);
    pop("t2_a_shift_caps", 24'h61401C);
    pop("t2_bang", 24'h214016);

    // Ctrl held forces 0xFF; Enter and Space after release
    do_reset();
    send(8'h14); send(8'h1C); send(8'hF0); send(8'h14); send(8'h5A); send(8'h29);
    pop("t2_ctrl_mk",  24'hFF0014);
    pop("t2_ctrl_a",   24'hFF801C);
    pop("t2_ctrl_brk", 24'hFF8094);
    pop("t2_enter",    24'h0D005A);
    pop("t2_space",    24'h200029);

    // 3: extended keys, restart mid-break, responses, pause
    do_reset();
    send(8'hE0); send(8'h74);
    chk("t3_right_held", key_state[7'h67], 1'b1);
    pop("t3_right_mk", 24'hFF0067);
    send(8'hE0); send(8'hF0); send(8'h74);
    pop("t3_right_brk", 24'hFF00E7);
    send(8'hE0); send(8'hF0); send(8'hE0); send(8'h75);
    pop("t3_restart_up_mk", 24'hFF0068);
    send(8'hFA); send(8'hE0); send(8'h12);
    chk("t3_ignored", fifo_count, 5'd0);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0);
    chk("t3_pause_pending", fifo_count, 5'd0);
    send(8'h77);
    chk("t3_pause_cnt", fifo_count, 5'd1);
    pop("t3_pause", 24'hFF007F);
    chk("t3_pause_ks", key_state, 128'h1 << 7'h68);
    send(8'h1C);
    pop("t3_after_pause", MK_A);

    // 4: overflow on DEPTH+1 events, then simultaneous push+pop on full
    do_reset();
    fill_pairs(DEPTH / 2);
    chk("t4_full_cnt", fifo_count, 5'd16);
    chk("t4_no_ovf", overflow, 1'b0);
    send(8'h1C);
    chk("t4_drop_cnt", fifo_count, 5'd16);
    chk("t4_ovf", overflow, 1'b1);
    chk("t4_drop_ks", key_state[7'h1C], 1'b1);
    chk("t4_head", evt_data, MK_A);
    do_reset();
    fill_pairs(DEPTH / 2);
    send_rdy(8'h1C, 1'b1);
    chk("t4_pp_cnt", fifo_count, 5'd16);
    chk("t4_pp_ovf", overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      pop($sformatf("t4_drain%0d", i), (i % 2 == 0) ? BRK_A : MK_A);
    evt_ready = 1'b1;
    @(negedge CLOCK_50);
    evt_ready = 1'b0;
    chk("t4_empty_pop_cnt", fifo_count, 5'd0);
    chk("t4_empty_pop_dat", evt_data, 24'h0);

    // 5: typematic repeats
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C);
`ifdef TYPEMATIC_FILTER_EN
    chk("t5_repeat_cnt", fifo_count, 5'd1);
`else
    chk("t5_repeat_cnt", fifo_count, 5'd3);
`endif

    // 6: reset mid-sequence
    do_reset();
    send(8'h1C); send(8'hE0); send(8'hF0);
    do_reset();
    chk("t6_cnt", fifo_count, 5'd0);
    chk("t6_vld", evt_valid, 1'b0);
    chk("t6_ks", key_state, 128'h0);
    send(8'h1C);
    chk("t6_cnt1", fifo_count, 5'd1);
    pop("t6_plain_make", MK_A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
